// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/forwarding control for an in-order pipeline.
// Tracks rd metadata of the DEPTH registers after ID and steers EX operands.
// Ports:
//   clk, rst             clock, async active-high reset
//   id_*                 sources/dest/flags of the instruction in ID
//   ex_redirect          taken control transfer resolved in EX
//   ext_stall            memory wait, freezes the whole pipeline
//   stall_if_id          hold PC and IF/ID
//   bubble_id_ex         load NOP controls into ID/EX
//   flush_if_id          invalidate IF/ID
//   freeze               all pipeline registers hold
//   fwd_sel_rs1/rs2      registered EX operand source (0 = RF, k = reg k)
//   wb_valid             last tracked register holds a valid instruction
// Optional: define PIPE_CTRL_PERF_EN to add saturating perf_stall_cnt and
// perf_flush_cnt outputs (CNT_W bits each).
module pipe_hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 32,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              ext_stall,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              freeze,
  output logic [SW-1:0]     fwd_sel_rs1,
  output logic [SW-1:0]     fwd_sel_rs2,
  output logic              wb_valid
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  if (DEPTH < 2 || ALU_READY < 1 || ALU_READY > LOAD_READY ||
      LOAD_READY > DEPTH || CNT_W < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: illegal parameter set");
  end

  // Entry DEPTH never forwards (write-first RF), so only its valid
  // bit is kept; the other fields stop at DEPTH-1.
  logic [DEPTH:1]   v;
  logic [DEPTH-1:1] w;
  logic [DEPTH-1:1] l;
  logic [REG_AW-1:0] rd [1:DEPTH-1];

  logic          hz1, hz2, hazard, load1;
  logic [SW-1:0] m1, m2;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    m1  = '0;
    m2  = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (v[k] && w[k] && rd[k] == id_rs1 &&
          id_rs1 != '0 && id_rs1_used) begin
        m1  = SW'(k + 1);
        hz1 = (k + 1) < (l[k] ? LOAD_READY : ALU_READY);
      end
      if (v[k] && w[k] && rd[k] == id_rs2 &&
          id_rs2 != '0 && id_rs2_used) begin
        m2  = SW'(k + 1);
        hz2 = (k + 1) < (l[k] ? LOAD_READY : ALU_READY);
      end
    end
  end

  assign hazard = hz1 | hz2;

  // Outputs are forced low while reset is held.
  assign stall_if_id  = ~rst & id_valid & hazard &
                        ~ex_redirect & ~ext_stall;
  assign flush_if_id  = ~rst & ex_redirect & ~ext_stall;
  assign bubble_id_ex = stall_if_id | flush_if_id;
  assign freeze       = ~rst & ext_stall;
  assign load1        = id_valid & ~bubble_id_ex;
  assign wb_valid     = v[DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      w <= '0;
      l <= '0;
      for (int k = 1; k <= DEPTH - 1; k++) rd[k] <= '0;
      fwd_sel_rs1 <= '0;
      fwd_sel_rs2 <= '0;
    end else if (!ext_stall) begin
      for (int k = DEPTH; k >= 2; k--) v[k] <= v[k-1];
      for (int k = DEPTH - 1; k >= 2; k--) begin
        w[k]  <= w[k-1];
        l[k]  <= l[k-1];
        rd[k] <= rd[k-1];
      end
      v[1]  <= load1;
      w[1]  <= id_reg_write;
      l[1]  <= id_is_load;
      rd[1] <= id_rd;
      fwd_sel_rs1 <= load1 ? m1 : '0;
      fwd_sel_rs2 <= load1 ? m2 : '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if_id && !(&perf_stall_cnt))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush_if_id && !(&perf_flush_cnt))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Directed per-cycle vectors; a negedge monitor pops expected outputs.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic       clk, rst;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_is_load, ex_redirect, ext_stall;
  logic       stall_if_id, bubble_id_ex, flush_if_id, freeze;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic       wb_valid;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .freeze(freeze),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .wb_valid(wb_valid)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       st, bb, fl, fr;
    logic [1:0] s1, s2;
    logic       wb;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (stall_if_id === e.st && bubble_id_ex === e.bb &&
          flush_if_id === e.fl && freeze === e.fr &&
          fwd_sel_rs1 === e.s1 && fwd_sel_rs2 === e.s2 &&
          wb_valid === e.wb)
        passed++;
      else
        $display("FAIL %s: got st%b bb%b fl%b fr%b s1=%0d s2=%0d wb%b, want st%b bb%b fl%b fr%b s1=%0d s2=%0d wb%b",
                 e.nm, stall_if_id, bubble_id_ex, flush_if_id, freeze,
                 fwd_sel_rs1, fwd_sel_rs2, wb_valid,
                 e.st, e.bb, e.fl, e.fr, e.s1, e.s2, e.wb);
    end
  end

  task automatic cyc(input string nm, input logic iv,
                     input int rs1, input int rs2,
                     input logic u1, input logic u2, input int rd,
                     input logic rw, input logic ld,
                     input logic rdr, input logic xs,
                     input logic st, input logic bb,
                     input logic fl, input logic fr,
                     input int s1, input int s2, input logic wb,
                     input bit chk = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid     = iv;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rs1_used  = u1;
    id_rs2_used  = u2;
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_is_load   = ld;
    ex_redirect  = rdr;
    ext_stall    = xs;
    e.nm = nm; e.st = st; e.bb = bb; e.fl = fl; e.fr = fr;
    e.s1 = 2'(s1); e.s2 = 2'(s2); e.wb = wb;
    if (chk) q.push_back(e);
  endtask

  task automatic nop(input string nm, input int s1, input int s2,
                     input logic wb);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, s1, s2, wb);
  endtask

  task automatic chk_zero(input string nm);
    total++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, freeze,
         fwd_sel_rs1, fwd_sel_rs2, wb_valid} === '0)
      passed++;
    else
      $display("FAIL %s: got st%b bb%b fl%b fr%b s1=%0d s2=%0d wb%b, want all 0",
               nm, stall_if_id, bubble_id_ex, flush_if_id, freeze,
               fwd_sel_rs1, fwd_sel_rs2, wb_valid);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1; id_rs1 = 5; id_rs2 = 5;
    id_rs1_used = 1; id_rs2_used = 1; id_rd = 5;
    id_reg_write = 1; id_is_load = 1;
    ex_redirect = 1; ext_stall = 1;
    #2;
    chk_zero("reset");
    #10;
    rst = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd = 0;
    id_reg_write = 0; id_is_load = 0;
    ex_redirect = 0; ext_stall = 0;

    // ALU producer then consumer: forward from EX/MEM
    cyc("alu_p", 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("alu_c", 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("alu_fwd", 2, 0, 0);
    nop("alu_d1", 0, 0, 1);
    nop("alu_d2", 0, 0, 1);
    nop("alu_d3", 0, 0, 0);

    // load-use: one stall, then forward from MEM/WB
    cyc("lu_lw", 1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_stall", 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("lu_go", 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("lu_fwd", 3, 3, 1);
    nop("lu_d1", 0, 0, 0);
    nop("lu_d2", 0, 0, 1);
    nop("lu_d3", 0, 0, 0);

    // load, gap, consumer with x0
    cyc("gap_lw", 1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("gap_nop", 0, 0, 0);
    cyc("gap_c", 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("gap_fwd", 3, 0, 1);
    nop("gap_d1", 0, 0, 0);
    nop("gap_d2", 0, 0, 1);
    nop("gap_d3", 0, 0, 0);

    // two producers of x7: youngest wins
    cyc("x7_a", 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("x7_b", 1, 3, 4, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("x7_c", 1, 7, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("young_fwd", 2, 0, 1);
    nop("x7_d1", 0, 0, 1);
    nop("x7_d2", 0, 0, 1);
    nop("x7_d3", 0, 0, 0);

    // redirect beats a pending load-use hazard
    cyc("rd_lw", 1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rd_flush", 1, 5, 5, 1, 1, 6, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    nop("rd_d1", 0, 0, 0);
    nop("rd_d2", 0, 0, 1);
    nop("rd_e1inv", 0, 0, 0);

    // ext_stall beats redirect and hazard; state holds
    cyc("fz_lw", 1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("fz_pri", 1, 5, 5, 1, 1, 6, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc("fz_hold", 1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc("fz_stall", 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("fz_go", 1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("fz_fwd", 3, 3, 1);
    nop("fz_d1", 0, 0, 0);
    nop("fz_d2", 0, 0, 1);

    // async reset in the middle of a stall
    cyc("rs_lw", 1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rs_stall", 1, 5, 5, 1, 1, 7, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("rs_go", 1, 5, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rs_lw9", 1, 7, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 3, 3, 1);
    cyc("rs_stall2", 1, 9, 0, 1, 1, 10, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    #1;
    rst = 1'b0;
    cyc("rs_after", 1, 9, 0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("rs_idle", 0, 0, 0);

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (perf_stall_cnt === '0 && perf_flush_cnt === '0) passed++;
    else $display("FAIL perf_reset: got %0d/%0d, want 0/0",
                  perf_stall_cnt, perf_flush_cnt);
    #1;
    rst = 1'b0;
    // chained loads stall every other cycle: 20 stalls in 40 cycles
    for (int i = 0; i < 40; i++)
      cyc("pf", 1, 5, 0, 1, 0, 5, 1, 1, 0, 0,
          0, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++)
      cyc("pf", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
          0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc("pf", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    total++;
    if (perf_stall_cnt === 4'd15) passed++;
    else $display("FAIL perf_stall_sat: got %0d, want 15", perf_stall_cnt);
    total++;
    if (perf_flush_cnt === 4'd2) passed++;
    else $display("FAIL perf_flush: got %0d, want 2", perf_flush_cnt);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. Replaces the fixed 5-stage hazard_detection/forwarding_unit pair.
- Tracks destination-register metadata for every pipeline register after ID.
- Issues load-use stalls, bubble insertion, redirect flushes and registered per-operand forwarding selects aligned to EX.
- Depth and result-ready stages are generics, so deeper pipelines reuse the block.

Parameters:
- DEPTH, 3: number of pipeline registers after ID. Index 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB. Minimum 2.
- REG_AW, 5: register address width.
- ALU_READY, 2: lowest register index holding a non-load result.
- LOAD_READY, 3: lowest register index holding a load result. Constraint: 1 <= ALU_READY <= LOAD_READY <= DEPTH.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  instruction in ID is valid
- id_rs1, id_rs2  in  REG_AW  source registers of the ID instruction
- id_rs1_used, id_rs2_used  in  1  source is actually read
- id_rd  in  REG_AW  destination register of the ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_redirect  in  1  branch/jal/jalr taken, resolved in EX
- ext_stall  in  1  memory wait; freezes whole pipeline
- stall_if_id  out  1  hold PC and IF/ID
- bubble_id_ex  out  1  load NOP controls into ID/EX
- flush_if_id  out  1  invalidate IF/ID
- freeze  out  1  all pipeline registers hold
- fwd_sel_rs1, fwd_sel_rs2  out  $clog2(DEPTH+1)  EX operand source: 0 = register file, k = pipeline register k
- wb_valid  out  1  entry DEPTH holds a valid instruction

Behaviour:
- Reset (async, any time including mid-stall): all entries invalid; all outputs 0.
- State: entry[1..DEPTH], each {valid, rd, reg_write, is_load}.
- Match rule: entry k matches source s when valid & reg_write & rd == s & s != 0 & s_used. The youngest match (lowest k) wins. Entry DEPTH never matches, because the register file is write-first.
- Hazard: a winning match at k with k+1 < ready, where ready = LOAD_READY if is_load, else ALU_READY.
- Output equations:
  - stall_if_id = id_valid & hazard & ~ex_redirect & ~ext_stall
  - bubble_id_ex = stall_if_id | (ex_redirect & ~ext_stall)
  - flush_if_id = ex_redirect & ~ext_stall
  - freeze = ext_stall
- Priority: ext_stall > ex_redirect > hazard.
- ex_redirect is ignored while ext_stall = 1; the source holds it until accepted.
- Advance (ext_stall = 0), same edge:
  - entry[k+1] <= entry[k] for all k; entry DEPTH drops out.
  - entry[1] <= ID info if id_valid & ~bubble_id_ex, else invalid.
  - fwd_sel_* <= k+1 of the winning match, or 0. Forced to 0 when entry[1] is loaded invalid.
- Freeze: entries and fwd_sel_* hold.
- Latency: selects are registered and apply to the instruction in EX one cycle after its ID decision.
- Load-use with defaults gives exactly one stall cycle, then fwd_sel = 3.
- Both sources matching different entries: each select is resolved independently. The stall is the OR of both hazards.
- A stalled ID instruction re-evaluates every cycle; the stall self-clears as the producer advances.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt and perf_flush_cnt, each CNT_W bits.
  - perf_stall_cnt increments on cycles with stall_if_id = 1; perf_flush_cnt increments on cycles with flush_if_id = 1.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD x5 followed by ADD x6,x5,x1 (defaults) -> no stall; consumer in EX sees fwd_sel_rs1 = 2.
- LW x5 followed by ADD x6,x5,x5 -> stall_if_id = 1 and bubble_id_ex = 1 for exactly 1 cycle; then fwd_sel_rs1 = fwd_sel_rs2 = 3.
- LW x5 / NOP / ADD x6,x5,x0 -> no stall; fwd_sel_rs1 = 3; rs2 of x0 gives fwd_sel_rs2 = 0.
- Producers ADD x7 at entry 2 and ADD x7 at entry 1 both match consumer rs1 = x7 -> youngest wins, fwd_sel_rs1 = 2.
- Load-use hazard pending while ex_redirect = 1 -> stall_if_id = 0, flush_if_id = 1, entry[1] invalid. Same with ext_stall = 1 -> only freeze = 1, state held.
- rst pulsed mid-stall, asynchronously -> all outputs 0 immediately, wb_valid = 0. With PIPE_CTRL_PERF_EN and CNT_W = 4, 20 stall cycles give perf_stall_cnt = 15.
